// File: rtl/axilite_seq_pkg.sv
// Shared types and constants for the AXI-lite command sequencer.
// Provides the FSM state encoding, the command payload carried through the
// FIFO, AXI response codes and default bus widths.
package axilite_seq_pkg;

  localparam int unsigned SEQ_ADDR_W = 32;
  localparam int unsigned SEQ_DATA_W = 64;
  localparam int unsigned SEQ_STRB_W = SEQ_DATA_W / 8;
  localparam int unsigned ERR_CNT_W  = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESP
  } seq_state_t;

  typedef struct packed {
    logic                  w_r;
    logic [SEQ_ADDR_W-1:0] addr;
    logic [SEQ_DATA_W-1:0] data;
    logic [SEQ_STRB_W-1:0] strb;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  // SLVERR and DECERR both have the upper bit set.
  function automatic logic is_err_resp(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axilite_cmd_sequencer_if.sv
// Bus bundle for the command sequencer: command producer port, AXI-lite
// master user interface, response port and status outputs.
// Modport master: the sequencer side. Modport slave: the environment side
// (command producer, AXI-lite master and response consumer).
interface axilite_cmd_sequencer_if
  import axilite_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = SEQ_ADDR_W,
  parameter int unsigned DATA_W = SEQ_DATA_W
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // Command producer
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_w_r;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [STRB_W-1:0] cmd_strb;

  // AXI-lite master user interface
  logic              user_start;
  logic              user_w_r;
  logic [ADDR_W-1:0] user_addr_in;
  logic [DATA_W-1:0] user_data_in;
  logic [STRB_W-1:0] user_data_strb;
  logic              user_free;
  logic [1:0]        user_status;
  logic [DATA_W-1:0] user_data_out;
  logic              user_data_out_valid;
  logic              user_w_r_out;
  logic [ADDR_W-1:0] user_addr_out;

  // Response port
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_w_r;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_status;

  // Status
  logic              busy;
  logic [15:0]       err_count;
  logic              timeout_flag;

  modport master (
    input  cmd_valid, cmd_w_r, cmd_addr, cmd_data, cmd_strb,
    output cmd_ready,
    output user_start, user_w_r, user_addr_in, user_data_in, user_data_strb,
    input  user_free, user_status, user_data_out, user_data_out_valid,
    input  user_w_r_out, user_addr_out,
    output rsp_valid, rsp_w_r, rsp_addr, rsp_data, rsp_status,
    input  rsp_ready,
    output busy, err_count, timeout_flag
  );

  modport slave (
    output cmd_valid, cmd_w_r, cmd_addr, cmd_data, cmd_strb,
    input  cmd_ready,
    input  user_start, user_w_r, user_addr_in, user_data_in, user_data_strb,
    output user_free, user_status, user_data_out, user_data_out_valid,
    output user_w_r_out, user_addr_out,
    input  rsp_valid, rsp_w_r, rsp_addr, rsp_data, rsp_status,
    output rsp_ready,
    input  busy, err_count, timeout_flag
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO (holds cmd_t in the sequencer).
// Ports: clk, rst (sync, active-high), push/wdata, pop, head_c (current head,
// valid when !empty), full/empty/count (registered), count_next_c (occupancy
// after this cycle's push/pop). DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // Pointer/occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head_c       = mem_q[rd_ptr_q];
  assign full         = full_q;
  assign empty        = empty_q;
  assign count        = count_q;
  assign count_next_c = count_d;

endmodule

// File: rtl/axilite_cmd_sequencer.sv
// Command front-end for the AXI-lite master: buffers commands in a FWFT FIFO,
// issues them one at a time on user_start, detects completion on the rising
// edge of user_data_out_valid and returns one response per command.
// Ports: aclk, areset (sync, active-high), bus (master modport: cmd_*, user_*,
// rsp_*, busy, err_count, timeout_flag). ADDR_W/DATA_W must match the package
// widths used for the command payload.
module axilite_cmd_sequencer
  import axilite_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = SEQ_ADDR_W,
  parameter int unsigned DATA_W      = SEQ_DATA_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   aclk,
  input  logic                   areset,
  axilite_cmd_sequencer_if.master bus
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

  seq_state_t         state_q, state_d;
  cmd_t               cmd_in_c;
  cmd_t               fifo_head_c;
  cmd_t               shadow_q, shadow_d;
  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count, fifo_count_next_c;
  logic               done_q, done_d, done_c;
  logic               addr_mismatch_c;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               timeout_q, timeout_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               user_start_q, user_start_d;
  logic               user_w_r_q, user_w_r_d;
  logic [ADDR_W-1:0]  user_addr_q, user_addr_d;
  logic [DATA_W-1:0]  user_data_q, user_data_d;
  logic [STRB_W-1:0]  user_strb_q, user_strb_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_w_r_q, rsp_w_r_d;
  logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [1:0]         rsp_status_q, rsp_status_d;

  // Command buffer
  assign cmd_in_c  = '{w_r: bus.cmd_w_r, addr: bus.cmd_addr,
                       data: bus.cmd_data, strb: bus.cmd_strb};
  assign fifo_push = bus.cmd_valid & cmd_ready_q;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (aclk),
    .rst          (areset),
    .push         (fifo_push),
    .wdata        (cmd_in_c),
    .pop          (fifo_pop),
    .head_c       (fifo_head_c),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count),
    .count_next_c (fifo_count_next_c)
  );

  // The master keeps valid high until its next address phase, so only a
  // rising edge marks a new completion.
  assign done_d          = bus.user_data_out_valid;
  assign done_c          = bus.user_data_out_valid & ~done_q;
  assign addr_mismatch_c = (bus.user_addr_out != shadow_q.addr);

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    shadow_d     = shadow_q;
    tmo_cnt_d    = tmo_cnt_q;
    timeout_d    = timeout_q;
    err_cnt_d    = err_cnt_q;
    rsp_w_r_d    = rsp_w_r_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && bus.user_free) state_d = ISSUE;
      end
      ISSUE: begin
        fifo_pop  = 1'b1;
        shadow_d  = fifo_head_c;
        tmo_cnt_d = '0;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_c) begin
          rsp_w_r_d    = bus.user_w_r_out;
          rsp_addr_d   = bus.user_addr_out;
          rsp_data_d   = bus.user_w_r_out ? bus.user_data_out : '0;
          rsp_status_d = addr_mismatch_c ? RESP_SLVERR : bus.user_status;
          if (is_err_resp(bus.user_status) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
          state_d = RESP;
        end else begin
          // Keep waiting after timeout; the counter just saturates.
          if (tmo_cnt_q != TMO_W'(TIMEOUT_CYC)) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (tmo_cnt_d == TMO_W'(TIMEOUT_CYC)) timeout_d = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs registered from the next state so they line up with state_q.
    user_start_d = (state_d == ISSUE);
    user_w_r_d   = user_start_d ? fifo_head_c.w_r  : 1'b0;
    user_addr_d  = user_start_d ? fifo_head_c.addr : '0;
    user_data_d  = user_start_d ? fifo_head_c.data : '0;
    user_strb_d  = user_start_d ? fifo_head_c.strb : '0;
    rsp_valid_d  = (state_d == RESP);
    busy_d       = (fifo_count_next_c != '0) || (state_d != IDLE);
    cmd_ready_d  = (fifo_count_next_c != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      done_q       <= 1'b0;
      tmo_cnt_q    <= '0;
      timeout_q    <= 1'b0;
      err_cnt_q    <= '0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      user_start_q <= 1'b0;
      user_w_r_q   <= 1'b0;
      user_addr_q  <= '0;
      user_data_q  <= '0;
      user_strb_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_w_r_q    <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      done_q       <= done_d;
      tmo_cnt_q    <= tmo_cnt_d;
      timeout_q    <= timeout_d;
      err_cnt_q    <= err_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      user_start_q <= user_start_d;
      user_w_r_q   <= user_w_r_d;
      user_addr_q  <= user_addr_d;
      user_data_q  <= user_data_d;
      user_strb_q  <= user_strb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_w_r_q    <= rsp_w_r_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.user_start     = user_start_q;
  assign bus.user_w_r       = user_w_r_q;
  assign bus.user_addr_in   = user_addr_q;
  assign bus.user_data_in   = user_data_q;
  assign bus.user_data_strb = user_strb_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_w_r        = rsp_w_r_q;
  assign bus.rsp_addr       = rsp_addr_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_status     = rsp_status_q;
  assign bus.busy           = busy_q;
  assign bus.err_count      = err_cnt_q;
  assign bus.timeout_flag   = timeout_q;

  // Completion must echo the address that was issued.
  a_addr_match: assert property (@(posedge aclk) disable iff (areset)
    (state_q == WAIT_DONE && done_c) |-> !addr_mismatch_c)
    else $error("axilite_cmd_sequencer: completion address differs from issued address");

  // Pushes are gated by cmd_ready, so the FIFO never overflows.
  a_no_overflow: assert property (@(posedge aclk) disable iff (areset)
    fifo_push |-> (!fifo_full && fifo_count < CNT_W'(FIFO_DEPTH)))
    else $error("axilite_cmd_sequencer: push into full command FIFO");

endmodule
